// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT datapath complex-multiply stage.
package fft_pkg;

    localparam int DATA_W_DEF = 16;   // input component width
    localparam int FRAC_W_DEF = 14;   // fractional bits of the twiddle (Q1.14)
    localparam int OUT_W_DEF  = 16;   // output component width after saturation
    localparam int TAG_W_DEF  = 4;    // sideband tag width
    localparam int LATENCY    = 4;    // enabled cycles from input transfer to out_valid

    // One complex sample at the default component width.
    typedef struct packed {
        logic signed [DATA_W_DEF-1:0] re;
        logic signed [DATA_W_DEF-1:0] im;
    } cplx_t;

endpackage

// File: rtl/cmul_pipe_if.sv
// Valid/ready stream bundle for cmul_pipe: operand side and result side.
interface cmul_pipe_if import fft_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     conj_b;
    logic signed [DATA_W-1:0] a_re;
    logic signed [DATA_W-1:0] a_im;
    logic signed [DATA_W-1:0] b_re;
    logic signed [DATA_W-1:0] b_im;
    logic [TAG_W-1:0]         in_tag;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_re;
    logic signed [OUT_W-1:0]  out_im;
    logic [TAG_W-1:0]         out_tag;
    logic                     out_sat;

    // Producer of operands and consumer of results.
    modport master (
        output in_valid, conj_b, a_re, a_im, b_re, b_im, in_tag, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_tag, out_sat
    );

    // The multiplier itself.
    modport slave (
        input  in_valid, conj_b, a_re, a_im, b_re, b_im, in_tag, out_ready,
        output in_ready, out_valid, out_re, out_im, out_tag, out_sat
    );
endinterface

// File: rtl/cmul_pipe_sat_round.sv
// Combinational round-half-up, arithmetic right shift by FRAC_W, and
// saturation to a signed OUT_W result with a saturation flag.
module sat_round #(
    parameter int IN_W   = 36,
    parameter int FRAC_W = 14,
    parameter int OUT_W  = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    sat
);
    // One guard bit so adding the rounding constant can never wrap.
    localparam int EXT_W = IN_W + 1;
    localparam logic [EXT_W-1:0] ONE  = {{(EXT_W-1){1'b0}}, 1'b1};
    localparam logic [EXT_W-1:0] HALF = ONE << (FRAC_W - 1);
    localparam logic signed [EXT_W-1:0] MAXV = $signed((ONE << (OUT_W - 1)) - ONE);
    localparam logic signed [EXT_W-1:0] MINV = -$signed(ONE << (OUT_W - 1));

    logic signed [EXT_W-1:0] din_x;
    logic signed [EXT_W-1:0] biased;
    logic signed [EXT_W-1:0] shifted;

    // Bias, shift, then clamp into the output range.
    always_comb begin
        din_x   = {din[IN_W-1], din};
        biased  = din_x + $signed(HALF);
        shifted = biased >>> FRAC_W;
        dout    = shifted[OUT_W-1:0];
        sat     = 1'b0;
        if (shifted > MAXV) begin
            dout = MAXV[OUT_W-1:0];
            sat  = 1'b1;
        end else if (shifted < MINV) begin
            dout = MINV[OUT_W-1:0];
            sat  = 1'b1;
        end
    end
endmodule

// File: rtl/cmul_pipe.sv
// Four-stage pipelined fixed-point complex multiplier (3-multiplier Gauss
// form) with optional conjugation of b, round/saturate, valid/ready flow
// control and a sideband tag that follows each sample.
module cmul_pipe import fft_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
) (
    input logic       clk,
    input logic       rst,
    cmul_pipe_if.slave bus
);
    localparam int SUM_W  = DATA_W + 2;
    localparam int PROD_W = 2 * DATA_W + 3;
    localparam int FULL_W = 2 * DATA_W + 4;

    // Whole pipeline moves as one; a stalled result freezes every stage.
    logic en;
    logic v1_reg, v2_reg, v3_reg, v4_reg;

    assign en            = bus.out_ready | ~v4_reg;
    assign bus.in_ready  = en;
    assign bus.out_valid = v4_reg;

    // ---------------- S1 combinational: conjugate and pre-add ----------------
    logic signed [DATA_W:0]   b_im_w;
    logic signed [DATA_W:0]   bi_next;
    logic signed [SUM_W-1:0]  a_re_x, a_im_x, b_re_x, bi_x;
    logic signed [SUM_W-1:0]  s1_next, s2_next, s3_next;

    // Negation is done one bit wider so -(-2^(DATA_W-1)) stays exact.
    always_comb begin
        b_im_w  = {bus.b_im[DATA_W-1], bus.b_im};
        bi_next = bus.conj_b ? -b_im_w : b_im_w;
        a_re_x  = {{2{bus.a_re[DATA_W-1]}}, bus.a_re};
        a_im_x  = {{2{bus.a_im[DATA_W-1]}}, bus.a_im};
        b_re_x  = {{2{bus.b_re[DATA_W-1]}}, bus.b_re};
        bi_x    = {bi_next[DATA_W], bi_next};
        s1_next = a_re_x + a_im_x;
        s2_next = bi_x - b_re_x;
        s3_next = b_re_x + bi_x;
    end

    logic signed [SUM_W-1:0]  s1_reg, s2_reg, s3_reg;
    logic signed [DATA_W-1:0] a_re_reg, a_im_reg, b_re_reg;
    logic [TAG_W-1:0]         tag1_reg, tag2_reg, tag3_reg;

    // ---------------- S2 combinational: the three products ----------------
    logic signed [PROD_W-1:0] b_re_p, a_re_p, a_im_p, s1_p, s2_p, s3_p;
    logic signed [PROD_W-1:0] k1_next, k2_next, k3_next;
    logic signed [PROD_W-1:0] k1_reg, k2_reg, k3_reg;

    // Operands are sign-extended to the product width before multiplying.
    always_comb begin
        b_re_p  = {{(PROD_W-DATA_W){b_re_reg[DATA_W-1]}}, b_re_reg};
        a_re_p  = {{(PROD_W-DATA_W){a_re_reg[DATA_W-1]}}, a_re_reg};
        a_im_p  = {{(PROD_W-DATA_W){a_im_reg[DATA_W-1]}}, a_im_reg};
        s1_p    = {{(PROD_W-SUM_W){s1_reg[SUM_W-1]}}, s1_reg};
        s2_p    = {{(PROD_W-SUM_W){s2_reg[SUM_W-1]}}, s2_reg};
        s3_p    = {{(PROD_W-SUM_W){s3_reg[SUM_W-1]}}, s3_reg};
        k1_next = b_re_p * s1_p;
        k2_next = a_re_p * s2_p;
        k3_next = a_im_p * s3_p;
    end

    // ---------------- S3 combinational: post-add into full width ----------------
    logic signed [FULL_W-1:0] k1_f, k2_f, k3_f;
    logic signed [FULL_W-1:0] re_next, im_next;
    logic signed [FULL_W-1:0] full_reg [2];

    // re = k1 - k3, im = k1 + k2.
    always_comb begin
        k1_f    = {k1_reg[PROD_W-1], k1_reg};
        k2_f    = {k2_reg[PROD_W-1], k2_reg};
        k3_f    = {k3_reg[PROD_W-1], k3_reg};
        re_next = k1_f - k3_f;
        im_next = k1_f + k2_f;
    end

    // ---------------- S4 combinational: round and saturate (index 0 = re, 1 = im) ----------------
    logic signed [OUT_W-1:0] rnd [2];
    logic [1:0]              sat_flag;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sat
            sat_round #(
                .IN_W   (FULL_W),
                .FRAC_W (FRAC_W),
                .OUT_W  (OUT_W)
            ) u_sat_round (
                .din  (full_reg[gi]),
                .dout (rnd[gi]),
                .sat  (sat_flag[gi])
            );
        end
    endgenerate

    // Datapath registers for S1..S3; only valid bits need clearing on reset.
    always_ff @(posedge clk) begin
        if (en) begin
            s1_reg      <= s1_next;
            s2_reg      <= s2_next;
            s3_reg      <= s3_next;
            a_re_reg    <= bus.a_re;
            a_im_reg    <= bus.a_im;
            b_re_reg    <= bus.b_re;
            tag1_reg    <= bus.in_tag;
            k1_reg      <= k1_next;
            k2_reg      <= k2_next;
            k3_reg      <= k3_next;
            tag2_reg    <= tag1_reg;
            full_reg[0] <= re_next;
            full_reg[1] <= im_next;
            tag3_reg    <= tag2_reg;
        end
    end

    logic signed [OUT_W-1:0] out_re_reg, out_im_reg;
    logic [TAG_W-1:0]        out_tag_reg;
    logic                    out_sat_reg;

    // Stage valid bits and the S4 output register; reset drops all in-flight samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_reg      <= 1'b0;
            v2_reg      <= 1'b0;
            v3_reg      <= 1'b0;
            v4_reg      <= 1'b0;
            out_re_reg  <= '0;
            out_im_reg  <= '0;
            out_tag_reg <= '0;
            out_sat_reg <= 1'b0;
        end else if (en) begin
            v1_reg      <= bus.in_valid;
            v2_reg      <= v1_reg;
            v3_reg      <= v2_reg;
            v4_reg      <= v3_reg;
            out_re_reg  <= rnd[0];
            out_im_reg  <= rnd[1];
            out_tag_reg <= tag3_reg;
            out_sat_reg <= |sat_flag;
        end
    end

    assign bus.out_re  = out_re_reg;
    assign bus.out_im  = out_im_reg;
    assign bus.out_tag = out_tag_reg;
    assign bus.out_sat = out_sat_reg;

endmodule

// File: tb/tb_cmul_pipe.sv
// Directed bench for cmul_pipe: single-sample math vectors, a backpressured
// stream and a mid-stream reset, each checked against hand-computed values.
module tb_cmul_pipe;
    import fft_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cmul_pipe_if bus ();

    cmul_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic cplx_t cx(input int r, input int i);
        cplx_t c;
        c.re = r[DATA_W_DEF-1:0];
        c.im = i[DATA_W_DEF-1:0];
        return c;
    endfunction

    task automatic drive(input cplx_t a, input cplx_t b, input logic cj, input int tg);
        bus.in_valid = 1'b1;
        bus.a_re     = a.re;
        bus.a_im     = a.im;
        bus.b_re     = b.re;
        bus.b_im     = b.im;
        bus.conj_b   = cj;
        bus.in_tag   = tg[TAG_W_DEF-1:0];
    endtask

    // Called at posedge+1: transfer one sample, wait for its result and check it.
    task automatic send_one(input string nm, input cplx_t a, input cplx_t b, input logic cj,
                            input int tg, input int er, input int ei, input int es);
        int n;
        drive(a, b, cj, tg);
        chk({nm, "_in_ready"}, bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 1;
        while (bus.out_valid !== 1'b1 && n < 12) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_latency"}, n, LATENCY);
        chk({nm, "_re"}, bus.out_re, er);
        chk({nm, "_im"}, bus.out_im, ei);
        chk({nm, "_sat"}, bus.out_sat, es);
        chk({nm, "_tag"}, bus.out_tag, tg);
        $display("txn %s tag=%0d re=%0d im=%0d sat=%0d latency=%0d",
                 nm, bus.out_tag, bus.out_re, bus.out_im, bus.out_sat, n);
        @(posedge clk); #1;
        chk({nm, "_drained"}, bus.out_valid, 0);
    endtask

    int idx, rcv;
    logic in_fire, out_fire, prev_stall;
    logic signed [15:0] prev_re, prev_im;
    logic [3:0] prev_tag;

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.conj_b    = 1'b0;
        bus.a_re      = '0;
        bus.a_im      = '0;
        bus.b_re      = '0;
        bus.b_im      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_re", bus.out_re, 0);
        chk("rst_out_im", bus.out_im, 0);
        chk("rst_out_tag", bus.out_tag, 0);
        chk("rst_out_sat", bus.out_sat, 0);
        chk("rst_in_ready", bus.in_ready, 1);

        // Math vectors
        send_one("identity", cx(8192, 4096), cx(16384, 0), 1'b0, 1, 8192, 4096, 0);
        send_one("minus_j", cx(8192, 4096), cx(0, -16384), 1'b0, 2, 4096, -8192, 0);
        send_one("conj_j", cx(8192, 4096), cx(0, 16384), 1'b1, 3, 4096, -8192, 0);
        send_one("round_pos", cx(1, 0), cx(8192, 0), 1'b0, 4, 1, 0, 0);
        send_one("round_neg", cx(-1, 0), cx(8192, 0), 1'b0, 5, 0, 0, 0);
        send_one("sat_im", cx(-32768, -32768), cx(-32768, -32768), 1'b0, 6, 0, 32767, 1);
        send_one("sat_re", cx(-32768, 0), cx(-32768, 0), 1'b0, 7, 32767, 0, 1);

        // Backpressured stream: 8 samples, each multiplied by j (odd ones via conj).
        idx = 0;
        rcv = 0;
        prev_stall = 1'b0;
        prev_re = '0;
        prev_im = '0;
        prev_tag = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            bus.out_ready = !(cyc >= 6 && cyc <= 9);
            #1;
            if (prev_stall) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_re", bus.out_re, prev_re);
                chk("hold_im", bus.out_im, prev_im);
                chk("hold_tag", bus.out_tag, prev_tag);
            end
            if (cyc >= 6 && cyc <= 9)
                chk("stall_in_ready", bus.in_ready, 0);
            if (idx < 8) begin
                if (idx % 2 == 1)
                    drive(cx(1000 * (idx + 1), -500 * idx), cx(0, -16384), 1'b1, idx);
                else
                    drive(cx(1000 * (idx + 1), -500 * idx), cx(0, 16384), 1'b0, idx);
            end else begin
                bus.in_valid = 1'b0;
            end
            in_fire  = bus.in_valid && bus.in_ready;
            out_fire = bus.out_valid && bus.out_ready;
            if (out_fire) begin
                chk("stream_tag", bus.out_tag, rcv);
                chk("stream_re", bus.out_re, 500 * rcv);
                chk("stream_im", bus.out_im, 1000 * (rcv + 1));
                $display("txn stream tag=%0d re=%0d im=%0d cycle=%0d",
                         bus.out_tag, bus.out_re, bus.out_im, cyc);
                rcv++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_re    = bus.out_re;
            prev_im    = bus.out_im;
            prev_tag   = bus.out_tag;
            @(posedge clk); #1;
            if (in_fire) idx++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("stream_count", rcv, 8);

        // Reset with three samples in flight.
        for (int i = 0; i < 3; i++) begin
            drive(cx(100, 0), cx(16384, 0), 1'b0, 9 + i);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        for (int i = 0; i < 8; i++) begin
            chk("midrst_no_ghost", bus.out_valid, 0);
            @(posedge clk); #1;
        end
        send_one("after_rst", cx(-300, 700), cx(16384, 0), 1'b0, 12, -300, 700, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cmul_pipe.md
Name: cmul_pipe

Overview:
- Parametrised, pipelined fixed-point complex multiplier; next generation of the combinational FAST_MUL used by the radix-4 FFT datapath.
- Computes out = a × b (or a × conj(b)) with the 3-multiplier Gauss form, Q-format rescaling, rounding and saturation.
- Adds valid/ready flow control and a sideband tag so the butterfly/twiddle stage can stall and track sample indices.

Parameters:
- DATA_W, 16, width of each signed input component (a and b)
- FRAC_W, 14, fractional bits of b (twiddle Q1.FRAC_W); product is shifted right by FRAC_W. Legal range 1..2*DATA_W.
- OUT_W, 16, width of each signed output component after saturation
- TAG_W, 4, width of the sideband tag carried alongside each sample

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept an input this cycle
- conj_b  in  1  1 = multiply by conj(b); sampled with the input
- a_re, a_im  in  DATA_W each  signed operand a
- b_re, b_im  in  DATA_W each  signed operand b (twiddle)
- in_tag  in  TAG_W  sideband, returned unchanged with the result
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_re, out_im  out  OUT_W each  signed result
- out_tag  out  TAG_W  tag of this result
- out_sat  out  1  1 if either component saturated for this sample

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: all stage valid bits, out_valid, out_re, out_im, out_tag and out_sat go to 0. in_ready is 1 in the cycle after reset.
- Reset mid-operation: every in-flight sample is discarded and no output is produced for it.
- Pipeline enable: en = out_ready | ~out_valid. in_ready = en. All four stages advance together when en = 1 and hold when en = 0.
- Bubbles are not collapsed. A transfer occurs on in_valid & in_ready, or on out_valid & out_ready.
- Latency: exactly 4 enabled cycles from input transfer to out_valid.
- S1: register the operands. If conj_b, bi' = -b_im, otherwise bi' = b_im, computed on DATA_W+1 bits so that -(-2^(DATA_W-1)) is exact.
  - s1 = a_re + a_im
  - s2 = bi' - b_re
  - s3 = b_re + bi'
  - Each sum is DATA_W+2 bits, sign-extended.
- S2: k1 = b_re × s1, k2 = a_re × s2, k3 = a_im × s3, each 2·DATA_W+3 bits signed.
- S3: re_full = k1 - k3, im_full = k1 + k2, each 2·DATA_W+4 bits.
- S4:
  - Round half-up: add 2^(FRAC_W-1), then arithmetic shift right by FRAC_W.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - out_sat = OR of the two per-component saturation flags.
  - Register results and the tag.
- Outputs hold stable while out_valid & ~out_ready.
- conj_b and in_tag travel with their sample and cannot affect other samples.
- Simultaneous input transfer and output transfer in the same cycle is legal, giving full throughput of 1 sample/cycle.

Decomposition:
- Shared package fft_pkg:
  - default DATA_W, FRAC_W and OUT_W constants
  - LATENCY = 4
  - a complex-sample struct type (re/im signed)
- One natural sub-module: sat_round, a combinational round-half-up, shift and saturate unit, instantiated twice in S4 (once for re, once for im).

Test Plan:
All scenarios use default parameters, with out_ready = 1 unless stated.
- Identity twiddle: a=(8192,4096), b=(16384,0), conj_b=0 -> out=(8192,4096), out_sat=0, out_valid exactly 4 cycles after the input transfer.
- Twiddle -j: a=(8192,4096), b=(0,-16384) -> out=(4096,-8192). Same a with b=(0,16384) and conj_b=1 -> out=(4096,-8192).
- Rounding: a=(1,0), b=(8192,0) -> out=(1,0). a=(-1,0), b=(8192,0) -> out=(0,0).
- Saturation: a=(-32768,-32768), b=(-32768,-32768) -> out=(0,32767), out_sat=1. a=(-32768,0), b=(-32768,0) -> out=(32767,0), out_sat=1.
- Backpressure: stream 8 samples with tags 0..7 back-to-back and hold out_ready=0 for cycles 6..9 -> in_ready=0 during the stall, outputs held stable, all 8 results arrive in tag order with no loss or duplication.
- Reset mid-stream: assert rst for 1 cycle while 3 samples are in flight -> out_valid=0 next cycle, none of the 3 results ever appear, and a new sample after reset returns after 4 cycles.
